xinlv_seg_disp: RTL and testbench

XINLV_SEG_DISP -- requirements
Module: xinlv_seg_disp

---
 rtl/xinlv_seg_disp.sv | 170 +++++++++++++++++
 tb/tb_xinlv_seg_disp.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/xinlv_seg_disp.sv
// xinlv_seg_disp
//   Converts a binary heart-rate value (bpm) into three BCD digits with a
//   serial double-dabble converter and drives a 4-digit, active-low,
//   multiplexed 7-segment display. The fourth digit shows a status letter
//   ('H' above HI_TH, 'L' below LO_TH) and 'alarm' follows that status.
//
// Ports
//   clk    in   system clock (only clock used)
//   rst_n  in   asynchronous active-low reset
//   xinlv  in   [7:0] heart rate in bpm, binary
//   seg    out  [7:0] active-low segments, seg[0..6]=a..g, seg[7]=dp
//   sel    out  [3:0] active-low digit enables: ones, tens, hundreds, status
//   alarm  out  high while displayed value is nonzero and out of range
//
// Configuration macro
//   XINLV_LZB_EN  when defined, leading zeros of the number are blanked.
module xinlv_seg_disp #(
  parameter int         CLK_FREQ = 50_000_000,
  parameter int         SCAN_HZ  = 1000,
  parameter logic [7:0] HI_TH    = 8'd120,
  parameter logic [7:0] LO_TH    = 8'd50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] xinlv,
  output logic [7:0] seg,
  output logic [3:0] sel,
  output logic       alarm
);

  localparam int SCAN_DIV = CLK_FREQ / SCAN_HZ;
  localparam int SCW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_DIV - 1);

  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_H     = 8'h89;
  localparam logic [7:0] SEG_L     = 8'hC7;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state;
  logic [7:0]  cap;
  logic [7:0]  sh;
  logic [11:0] bcd;
  logic [11:0] bcd_adj;
  logic [2:0]  bit_cnt;
  logic [3:0]  hundreds;
  logic [3:0]  tens;
  logic [3:0]  ones;
  logic [7:0]  disp_val;

  logic [SCW-1:0] scan_cnt;
  logic [1:0]     dig_idx;
  logic [7:0]     seg_next;

  function automatic logic [7:0] dig_code(input logic [3:0] d);
    case (d)
      4'd0:    dig_code = 8'hC0;
      4'd1:    dig_code = 8'hF9;
      4'd2:    dig_code = 8'hA4;
      4'd3:    dig_code = 8'hB0;
      4'd4:    dig_code = 8'h99;
      4'd5:    dig_code = 8'h92;
      4'd6:    dig_code = 8'h82;
      4'd7:    dig_code = 8'hF8;
      4'd8:    dig_code = 8'h80;
      4'd9:    dig_code = 8'h90;
      default: dig_code = SEG_BLANK;
    endcase
  endfunction

  // Add-3 correction applied to every BCD nibble that is 5 or more before
  // the next left shift.
  always_comb begin
    bcd_adj = bcd;
    if (bcd[3:0]  >= 4'd5) bcd_adj[3:0]  = bcd[3:0]  + 4'd3;
    if (bcd[7:4]  >= 4'd5) bcd_adj[7:4]  = bcd[7:4]  + 4'd3;
    if (bcd[11:8] >= 4'd5) bcd_adj[11:8] = bcd[11:8] + 4'd3;
  end

  // Converter FSM: capture on change while idle, 8 shift cycles, then load
  // the display registers. Changes arriving mid-conversion are picked up
  // on the next IDLE because cap still holds the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cap      <= 8'd0;
      sh       <= 8'd0;
      bcd      <= 12'd0;
      bit_cnt  <= 3'd0;
      hundreds <= 4'd0;
      tens     <= 4'd0;
      ones     <= 4'd0;
      disp_val <= 8'd0;
      alarm    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (xinlv != cap) begin
            cap     <= xinlv;
            sh      <= xinlv;
            bcd     <= 12'd0;
            bit_cnt <= 3'd0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          {bcd, sh} <= {bcd_adj[10:0], sh, 1'b0};
          bit_cnt   <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= DONE;
        end
        DONE: begin
          hundreds <= bcd[11:8];
          tens     <= bcd[7:4];
          ones     <= bcd[3:0];
          disp_val <= cap;
          alarm    <= (cap != 8'd0) && ((cap > HI_TH) || (cap < LO_TH));
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Segment pattern for the digit currently being scanned.
  always_comb begin
    seg_next = SEG_BLANK;
    if (disp_val == 8'd0) begin
      seg_next = SEG_DASH;
    end else begin
      case (dig_idx)
        2'd0: seg_next = dig_code(ones);
`ifdef XINLV_LZB_EN
        2'd1: seg_next = (hundreds == 4'd0 && tens == 4'd0) ? SEG_BLANK : dig_code(tens);
        2'd2: seg_next = (hundreds == 4'd0) ? SEG_BLANK : dig_code(hundreds);
`else
        2'd1: seg_next = dig_code(tens);
        2'd2: seg_next = dig_code(hundreds);
`endif
        default: begin
          if (disp_val > HI_TH)      seg_next = SEG_H;
          else if (disp_val < LO_TH) seg_next = SEG_L;
          else                       seg_next = SEG_BLANK;
        end
      endcase
    end
  end

  // Scan timer and digit multiplexer; seg and sel are registered together
  // from the same digit index so they always change on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      dig_idx  <= 2'd0;
      seg      <= SEG_BLANK;
      sel      <= 4'hF;
    end else begin
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        dig_idx  <= dig_idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      seg <= seg_next;
      sel <= ~(4'b0001 << dig_idx);
    end
  end

endmodule

// File: tb/tb_xinlv_seg_disp.sv
// Testbench for xinlv_seg_disp: 4 clock cycles per digit. A behavioural
// model derives every expected digit from the bpm value with plain
// division/modulo and the threshold rules.
module tb_xinlv_seg_disp;

  localparam int HI = 120;
  localparam int LO = 50;

  logic       clk;
  logic       rst_n;
  logic [7:0] xinlv;
  logic [7:0] seg;
  logic [3:0] sel;
  logic       alarm;

  int errorCount = 0;
  int checkCount = 0;
  int edgeCount;

  xinlv_seg_disp #(
    .CLK_FREQ(4000),
    .SCAN_HZ (1000),
    .HI_TH   (8'd120),
    .LO_TH   (8'd50)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .xinlv(xinlv),
    .seg  (seg),
    .sel  (sel),
    .alarm(alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release; used to predict the scanned digit.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edgeCount <= 0;
    else        edgeCount <= edgeCount + 1;
  end

  function automatic logic [7:0] digCode(input int d);
    case (d)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      default: return 8'h90;
    endcase
  endfunction

  function automatic logic [7:0] expSeg(input int val, input int idx);
    if (val == 0) return 8'hBF;
    case (idx)
      0: return digCode(val % 10);
`ifdef XINLV_LZB_EN
      1: return (val < 10) ? 8'hFF : digCode((val / 10) % 10);
      2: return (val < 100) ? 8'hFF : digCode(val / 100);
`else
      1: return digCode((val / 10) % 10);
      2: return digCode(val / 100);
`endif
      default: begin
        if (val > HI) return 8'h89;
        if (val < LO) return 8'hC7;
        return 8'hFF;
      end
    endcase
  endfunction

  function automatic logic expAlarm(input int val);
    return (val != 0) && (val > HI || val < LO);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Watch one full scan round (4 digits x 4 cycles) and compare every sample.
  task automatic scanCheck(input int val);
    int idx;
    repeat (16) begin
      @(negedge clk);
      idx = ((edgeCount - 1) / 4) % 4;
      checkOutput("sel", {28'd0, sel}, {28'd0, ~(4'b0001 << idx)});
      checkOutput("seg", {24'd0, seg}, {24'd0, expSeg(val, idx)});
      checkOutput("alarm", {31'd0, alarm}, {31'd0, expAlarm(val)});
    end
  endtask

  task automatic applyStimulus(input int val);
    @(negedge clk);
    xinlv = 8'(val);
    repeat (14) @(posedge clk);
    scanCheck(val);
  endtask

  int boundaryVals[12] = '{72, 135, 120, 121, 45, 50, 49, 0, 1, 255, 100, 9};

  initial begin
    rst_n = 1'b0;
    xinlv = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_seg", {24'd0, seg}, 32'hFF);
    checkOutput("reset_sel", {28'd0, sel}, 32'hF);
    checkOutput("reset_alarm", {31'd0, alarm}, 32'd0);
    rst_n = 1'b1;

    @(negedge clk);
    checkOutput("first_sel", {28'd0, sel}, 32'hE);
    checkOutput("first_seg", {24'd0, seg}, 32'hBF);
    scanCheck(0);

    foreach (boundaryVals[i]) applyStimulus(boundaryVals[i]);

    for (int i = 0; i < 10; i++) applyStimulus(int'($urandom_range(0, 255)));

    // Change arriving mid-conversion: 72 must complete, then 99 follows.
    applyStimulus(135);
    @(negedge clk);
    xinlv = 8'd72;
    repeat (4) @(posedge clk);
    @(negedge clk);
    xinlv = 8'd99;
    checkOutput("midshift_old_alarm", {31'd0, alarm}, 32'd1);
    repeat (8) @(posedge clk);
    @(negedge clk);
    checkOutput("midshift_72_alarm", {31'd0, alarm}, 32'd0);
    repeat (14) @(posedge clk);
    scanCheck(99);

    // Reset pulsed during SHIFT: outputs blank at once, then reconvert.
    @(negedge clk);
    xinlv = 8'd135;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset_seg", {24'd0, seg}, 32'hFF);
    checkOutput("midreset_sel", {28'd0, sel}, 32'hF);
    checkOutput("midreset_alarm", {31'd0, alarm}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (14) @(posedge clk);
    scanCheck(135);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
